xadc_drp_scanner: RTL



---
 rtl/xadc_drp_scanner_pkg.sv | 29 ++
 rtl/xadc_drp_scanner_bar_thermo.sv | 24 ++
 rtl/xadc_drp_scanner.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/xadc_drp_scanner_pkg.sv
// Shared constants for the XADC DRP scanner.
//   - FSM state encoding (S_IDLE..S_COMMIT) and the matching enum type
//   - XADC DRP register addresses for the auxiliary and temperature channels
//   - default overrange threshold
package xadc_drp_scanner_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACC    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    REQ    = S_REQ,
    WAIT   = S_WAIT,
    ACC    = S_ACC,
    COMMIT = S_COMMIT
  } state_t;

  localparam logic [6:0] TEMP   = 7'h00;
  localparam logic [6:0] VAUX6  = 7'h16;
  localparam logic [6:0] VAUX7  = 7'h17;
  localparam logic [6:0] VAUX14 = 7'h1e;
  localparam logic [6:0] VAUX15 = 7'h1f;

  localparam logic [15:0] OVR_DEFAULT = 16'hFFD0;

endpackage

// File: rtl/xadc_drp_scanner_bar_thermo.sv
// bar_thermo: combinational 16-bit value -> thermometer bargraph.
//   value  in  16        unsigned sample
//   bar    out NUM_LEDS  k+1 LEDs lit, k = top log2(NUM_LEDS) bits of value
module bar_thermo #(
  parameter int NUM_LEDS = 16
) (
  input  logic [15:0]         value,
  output logic [NUM_LEDS-1:0] bar
);

  localparam int LW = $clog2(NUM_LEDS);

  logic [LW-1:0] k;
  logic          unused_low;

  assign k          = value[15 -: LW];
  // Only the top bits pick the bar level; the rest are deliberately dropped.
  assign unused_low = ^value[15-LW:0];

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    assign bar[i] = (k >= LW'(i));
  end

endmodule

// File: rtl/xadc_drp_scanner.sv
// xadc_drp_scanner: round-robin XADC DRP poller with per-channel averaging.
//   clk, rst       clock, synchronous active-high reset
//   eoc            XADC end-of-conversion; starts a scan when FREE_RUN=0
//   drp_daddr/den  DRP read request (den is a one-cycle pulse)
//   drp_do/drdy    DRP read response
//   chan_sel       channel shown on result/bar/overrange (>= NUM_CH -> ch0)
//   result         committed average of selected channel, result_valid once committed
//   commit         one-cycle pulse when the result bank updates
//   bar            thermometer of result; overrange = result > OVR_THRESH
//   drp_err        sticky DRP timeout flag
module xadc_drp_scanner
  import xadc_drp_scanner_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter logic [NUM_CH*7-1:0] CH_ADDRS = {VAUX15, VAUX14, VAUX7, VAUX6},
  parameter int                AVG_LOG2   = 2,
  parameter bit                FREE_RUN   = 1'b0,
  parameter int                TIMEOUT    = 255,
  parameter int                NUM_LEDS   = 16,
  parameter logic [15:0]       OVR_THRESH = OVR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eoc,
  output logic [6:0]          drp_daddr,
  output logic                drp_den,
  input  logic [15:0]         drp_do,
  input  logic                drp_drdy,
  input  logic [2:0]          chan_sel,
  output logic [15:0]         result,
  output logic                result_valid,
  output logic                commit,
  output logic [NUM_LEDS-1:0] bar,
  output logic                overrange,
  output logic                drp_err
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [NUM_CH-1:0][AW-1:0] acc;
  logic [NUM_CH-1:0][15:0]   bank;
  logic [NUM_CH-1:0]         valid;

  state_t        state;
  logic [IW-1:0] idx;
  logic [RW-1:0] round;
  logic [7:0]    tcnt;
  logic [15:0]   sample;

  logic          last_ch, last_round;
  logic [IW-1:0] sel;
  logic [NUM_LEDS-1:0] bar_next;

  function automatic logic [6:0] ch_addr(input logic [IW-1:0] i);
    return CH_ADDRS[7*i +: 7];
  endfunction

  assign last_ch    = (idx == IW'(NUM_CH - 1));
  // With AVG_LOG2=0 the target is 0, so every scan is the last round.
  assign last_round = (round == RW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      round     <= '0;
      tcnt      <= '0;
      sample    <= '0;
      acc       <= '0;
      bank      <= '0;
      valid     <= '0;
      drp_den   <= 1'b0;
      drp_daddr <= CH_ADDRS[6:0];
      commit    <= 1'b0;
      drp_err   <= 1'b0;
    end else begin
      drp_den <= 1'b0;
      commit  <= 1'b0;
      case (state)
        IDLE: if (FREE_RUN || eoc) begin
          drp_daddr <= ch_addr(idx);
          drp_den   <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (drp_drdy) begin
            sample <= drp_do;
            state  <= ACC;
          end else if (tcnt == 8'(TIMEOUT)) begin
            // Lost response: reuse the last committed value so the average
            // stays sane while drp_err flags the fault.
            drp_err <= 1'b1;
            sample  <= bank[idx];
            state   <= ACC;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ACC: begin
          acc[idx] <= (round == '0) ? AW'(sample) : acc[idx] + AW'(sample);
          if (!last_ch) begin
            idx       <= idx + 1'b1;
            drp_daddr <= ch_addr(idx + 1'b1);
            drp_den   <= 1'b1;
            state     <= REQ;
          end else begin
            idx   <= '0;
            round <= last_round ? '0 : round + 1'b1;
            state <= last_round ? COMMIT : IDLE;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_CH; i++) bank[i] <= 16'(acc[i] >> AVG_LOG2);
          valid  <= '1;
          commit <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: one register after the bank/chan_sel.
  always_comb begin
    sel = '0;
    if (int'(chan_sel) < NUM_CH) sel = IW'(chan_sel);
  end

  bar_thermo #(.NUM_LEDS(NUM_LEDS)) u_bar (
    .value (bank[sel]),
    .bar   (bar_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrange    <= 1'b0;
      bar          <= NUM_LEDS'(1);
    end else begin
      result       <= bank[sel];
      result_valid <= valid[sel];
      overrange    <= (bank[sel] > OVR_THRESH);
      bar          <= bar_next;
    end
  end

endmodule
